online_result_collector: RTL and testbench

//  Receive end of the MSD-first signed-digit stream produced by the online multiplier/adder datapath.

---
 rtl/online_arith_pkg.sv | 42 ++++
 rtl/otf_digit_step.sv | 49 ++++
 rtl/online_result_collector.sv | 157 +++++++++++++++
 tb/tb_online_result_collector.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/online_arith_pkg.sv
// Shared definitions for the online-arithmetic result path: FSM state
// encodings, radix/width helpers and signed-digit legality check.
package online_arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SKIP    = 2'd1,
        ST_COLLECT = 2'd2,
        ST_HOLD    = 2'd3
    } otf_state_e;

    // Digit counter width; comfortably covers skip and collect counts.
    localparam int CNT_W = 8;

    // log2 of a power-of-two radix.
    function automatic int radix_log2(input int radix);
        int l;
        l = 0;
        for (int i = 0; i < 8; i++) begin
            if ((32'sd1 << i) < radix) begin
                l = i + 1;
            end else begin
                l = l;
            end
        end
        return l;
    endfunction

    // Width of the two's-complement result: sign bit plus one radix
    // position per collected digit.
    function automatic int result_width(input int n, input int radix);
        return 1 + n * radix_log2(radix);
    endfunction

    // A digit is legal when its magnitude does not exceed radix-1.
    function automatic logic digit_is_legal(input logic signed [7:0] digit, input int radix);
        int v;
        v = int'(digit);
        return (v <= radix - 1) && (v >= 1 - radix);
    endfunction

endpackage

// File: rtl/otf_digit_step.sv
// One on-the-fly conversion step: folds a signed digit into the Q/QM pair,
// where QM is always Q-1. Purely combinational so converters can share it.
module otf_digit_step
    import online_arith_pkg::*;
#(
    parameter int RW         = 5,
    parameter int RADIX_BITS = 2,
    parameter int RADIX      = 2
) (
    input  logic [RW-1:0]         q,
    input  logic [RW-1:0]         qm,
    input  logic [RADIX_BITS-1:0] digit,
    output logic [RW-1:0]         q_next,
    output logic [RW-1:0]         qm_next
);

    localparam int            LOG2R   = radix_log2(RADIX);
    localparam logic [RW-1:0] R_VAL   = RW'(RADIX);
    localparam logic [RW-1:0] ONE_VAL = RW'(32'd1);

    logic [RW-1:0] digit_ext_s;
    logic [RW-1:0] q_shift_s;
    logic [RW-1:0] qm_shift_s;
    logic          digit_neg_s;
    logic          digit_zero_s;

    assign digit_ext_s  = RW'($signed(digit));
    assign q_shift_s    = q << LOG2R;
    assign qm_shift_s   = qm << LOG2R;
    assign digit_neg_s  = digit[RADIX_BITS-1];
    assign digit_zero_s = (digit == {RADIX_BITS{1'b0}});

    // Select the Q or QM history depending on digit sign and append the digit.
    always_comb begin
        q_next  = q_shift_s + digit_ext_s;
        qm_next = qm_shift_s + ((R_VAL - ONE_VAL) + digit_ext_s);
        if (digit_neg_s) begin
            q_next = qm_shift_s + (R_VAL + digit_ext_s);
        end else begin
            q_next = q_shift_s + digit_ext_s;
        end
        if (!digit_neg_s && !digit_zero_s) begin
            qm_next = q_shift_s + (digit_ext_s - ONE_VAL);
        end else begin
            qm_next = qm_shift_s + ((R_VAL - ONE_VAL) + digit_ext_s);
        end
    end

endmodule

// File: rtl/online_result_collector.sv
// Receive side of an MSD-first signed-digit stream: drops the online-delay
// digits, converts the following digits on the fly and offers the
// two's-complement result on a valid/ready port.
module online_result_collector
    import online_arith_pkg::*;
#(
    parameter int  NO_OF_DIGITS = 4,
    parameter int  RADIX_BITS   = 2,
    parameter int  RADIX        = 2,
    parameter int  SKIP_DIGITS  = 3,
    localparam int RW           = result_width(NO_OF_DIGITS, RADIX)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [RADIX_BITS-1:0] digit_in,
    input  logic                  digit_valid,
    output logic [RW-1:0]         result,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic                  busy,
    output logic                  digit_err,
    output logic                  overrun
);

    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(32'd0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] SKIP_LAST = (SKIP_DIGITS > 0) ? CNT_W'(SKIP_DIGITS - 1) : CNT_W'(32'd0);
    localparam logic [CNT_W-1:0] COLL_LAST = CNT_W'(NO_OF_DIGITS - 1);

    otf_state_e       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [RW-1:0]    q_r;
    logic [RW-1:0]    qm_r;

    otf_state_e       eff_state_s;
    logic [CNT_W-1:0] eff_cnt_s;
    logic [RW-1:0]    eff_q_s;
    logic [RW-1:0]    eff_qm_s;
    logic             eff_err_s;
    logic [RW-1:0]    step_q_s;
    logic [RW-1:0]    step_qm_s;
    logic             digit_legal_s;

    assign digit_legal_s = digit_is_legal(8'($signed(digit_in)), RADIX);

    // A start pulse behaves as if the stream had just been cleared, so the
    // start-cycle digit is processed as stream index 0 from a fresh state.
    always_comb begin
        eff_state_s = state_r;
        eff_cnt_s   = cnt_r;
        eff_q_s     = q_r;
        eff_qm_s    = qm_r;
        eff_err_s   = digit_err;
        if (start) begin
            eff_state_s = (SKIP_DIGITS > 0) ? ST_SKIP : ST_COLLECT;
            eff_cnt_s   = CNT_ZERO;
            eff_q_s     = {RW{1'b0}};
            eff_qm_s    = {RW{1'b1}};
            eff_err_s   = 1'b0;
        end else begin
            eff_state_s = state_r;
            eff_cnt_s   = cnt_r;
            eff_q_s     = q_r;
            eff_qm_s    = qm_r;
            eff_err_s   = digit_err;
        end
    end

    otf_digit_step #(
        .RW         (RW),
        .RADIX_BITS (RADIX_BITS),
        .RADIX      (RADIX)
    ) u_step (
        .q       (eff_q_s),
        .qm      (eff_qm_s),
        .digit   (digit_in),
        .q_next  (step_q_s),
        .qm_next (step_qm_s)
    );

    // Collector FSM with registered result, status and pulse outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            cnt_r        <= CNT_ZERO;
            q_r          <= {RW{1'b0}};
            qm_r         <= {RW{1'b1}};
            result       <= {RW{1'b0}};
            result_valid <= 1'b0;
            busy         <= 1'b0;
            digit_err    <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            overrun   <= start && (state_r == ST_HOLD) && !result_ready;
            cnt_r     <= eff_cnt_s;
            q_r       <= eff_q_s;
            qm_r      <= eff_qm_s;
            digit_err <= eff_err_s;
            case (eff_state_s)
                ST_IDLE: begin
                    state_r      <= ST_IDLE;
                    busy         <= 1'b0;
                    result_valid <= 1'b0;
                end
                ST_SKIP: begin
                    state_r      <= ST_SKIP;
                    busy         <= 1'b1;
                    result_valid <= 1'b0;
                    if (digit_valid) begin
                        if (eff_cnt_s == SKIP_LAST) begin
                            state_r <= ST_COLLECT;
                            cnt_r   <= CNT_ZERO;
                        end else begin
                            cnt_r <= eff_cnt_s + CNT_ONE;
                        end
                    end
                end
                ST_COLLECT: begin
                    state_r      <= ST_COLLECT;
                    busy         <= 1'b1;
                    result_valid <= 1'b0;
                    if (digit_valid) begin
                        q_r       <= step_q_s;
                        qm_r      <= step_qm_s;
                        digit_err <= eff_err_s | ~digit_legal_s;
                        if (eff_cnt_s == COLL_LAST) begin
                            state_r      <= ST_HOLD;
                            cnt_r        <= CNT_ZERO;
                            busy         <= 1'b0;
                            result_valid <= 1'b1;
                            result       <= step_q_s;
                        end else begin
                            cnt_r <= eff_cnt_s + CNT_ONE;
                        end
                    end
                end
                ST_HOLD: begin
                    busy <= 1'b0;
                    if (result_ready) begin
                        state_r      <= ST_IDLE;
                        result_valid <= 1'b0;
                    end else begin
                        state_r      <= ST_HOLD;
                        result_valid <= 1'b1;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    busy         <= 1'b0;
                    result_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_online_result_collector.sv
// Self-checking bench for online_result_collector: radix-2 and radix-4
// instances, table vectors, hand-written corner sequences and random ops
// checked against a positional-sum reference model.
module tb_online_result_collector;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    // radix-2, N=4, skip 3
    logic       a_start, a_dv, a_ready;
    logic [1:0] a_digit;
    logic [4:0] a_result;
    logic       a_rv, a_busy, a_err, a_ov;
    // radix-4, N=3, skip 2
    logic       b_start, b_dv, b_ready;
    logic [2:0] b_digit;
    logic [6:0] b_result;
    logic       b_rv, b_busy, b_err, b_ov;

    online_result_collector #(
        .NO_OF_DIGITS(4), .RADIX_BITS(2), .RADIX(2), .SKIP_DIGITS(3)
    ) u_dut_a (
        .clk(clk), .reset_n(reset_n), .start(a_start), .digit_in(a_digit),
        .digit_valid(a_dv), .result(a_result), .result_valid(a_rv),
        .result_ready(a_ready), .busy(a_busy), .digit_err(a_err), .overrun(a_ov)
    );

    online_result_collector #(
        .NO_OF_DIGITS(3), .RADIX_BITS(3), .RADIX(4), .SKIP_DIGITS(2)
    ) u_dut_b (
        .clk(clk), .reset_n(reset_n), .start(b_start), .digit_in(b_digit),
        .digit_valid(b_dv), .result(b_result), .result_valid(b_rv),
        .result_ready(b_ready), .busy(b_busy), .digit_err(b_err), .overrun(b_ov)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        int         d[4];
        logic [4:0] exp;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: result is the positional value sum(q_j * r^(N-j)) modulo 2^RW.
    function automatic logic [4:0] model_a(input int d[4]);
        int acc;
        acc = 0;
        for (int j = 0; j < 4; j++) acc = acc * 2 + d[j];
        return 5'(acc);
    endfunction

    function automatic logic [6:0] model_b(input int d[3]);
        int acc;
        acc = 0;
        for (int j = 0; j < 3; j++) acc = acc * 4 + d[j];
        return 7'(acc);
    endfunction

    task automatic apply_a(input logic s, input logic v, input int d);
        a_start = s; a_dv = v; a_digit = 2'(d);
        tick();
        a_start = 1'b0; a_dv = 1'b0;
    endtask

    // Start, three junk digits, then the four result digits; optional
    // one-cycle digit_valid gaps after every valid digit but the last.
    task automatic run_a(input int dig[4], input bit gaps, input logic exp_ov, output int busy_cnt);
        int d;
        busy_cnt = 0;
        for (int k = 0; k < 7; k++) begin
            if (k < 3) d = int'($urandom_range(0, 3)) - 2;
            else       d = dig[k-3];
            apply_a((k == 0), 1'b1, d);
            if (k == 0) check("a_overrun_pulse", {31'd0, a_ov}, {31'd0, exp_ov});
            if (k == 1) check("a_overrun_clear", {31'd0, a_ov}, 32'd0);
            if (k == 5) check("a_rv_before_last", {31'd0, a_rv}, 32'd0);
            if (a_busy) busy_cnt++;
            if (gaps && k < 6) begin
                a_digit = 2'($urandom);
                tick();
                if (a_busy) busy_cnt++;
            end
        end
        check("a_rv_after_last", {31'd0, a_rv}, 32'd1);
        check("a_busy_in_hold", {31'd0, a_busy}, 32'd0);
    endtask

    task automatic accept_a();
        a_ready = 1'b1;
        tick();
        a_ready = 1'b0;
        check("a_rv_after_accept", {31'd0, a_rv}, 32'd0);
    endtask

    task automatic run_b(input int dig[3]);
        int d;
        for (int k = 0; k < 5; k++) begin
            if (k < 2) d = int'($urandom_range(0, 7)) - 4;
            else       d = dig[k-2];
            b_start = (k == 0); b_dv = 1'b1; b_digit = 3'(d);
            tick();
            b_start = 1'b0; b_dv = 1'b0;
        end
        check("b_rv_after_last", {31'd0, b_rv}, 32'd1);
        b_ready = 1'b1;
        tick();
        b_ready = 1'b0;
        check("b_rv_after_accept", {31'd0, b_rv}, 32'd0);
    endtask

    initial begin
        int dv4[4];
        int dv3[3];
        int bc;
        int bc_ref;
        logic [4:0] exp5;
        logic [6:0] exp7;
        logic       exp_err;

        reset_n = 1'b0;
        a_start = 1'b0; a_dv = 1'b0; a_ready = 1'b0; a_digit = 2'd0;
        b_start = 1'b0; b_dv = 1'b0; b_ready = 1'b0; b_digit = 3'd0;
        tick(); tick(); tick();
        check("rst_a_result", {27'd0, a_result}, 32'd0);
        check("rst_a_rv",     {31'd0, a_rv},     32'd0);
        check("rst_a_busy",   {31'd0, a_busy},   32'd0);
        check("rst_a_err",    {31'd0, a_err},    32'd0);
        check("rst_a_ov",     {31'd0, a_ov},     32'd0);
        check("rst_b_result", {25'd0, b_result}, 32'd0);
        check("rst_b_rv",     {31'd0, b_rv},     32'd0);
        reset_n = 1'b1;
        tick();

        // Table of digit strings with hand-computed results.
        tbl[0].d = '{1, 0, -1, 1};   tbl[0].exp = 5'b00111;
        tbl[1].d = '{-1, -1, -1, -1}; tbl[1].exp = 5'b10001;
        tbl[2].d = '{0, 0, 0, 0};    tbl[2].exp = 5'b00000;
        tbl[3].d = '{1, 1, 1, 1};    tbl[3].exp = 5'b01111;
        tbl[4].d = '{1, -1, 0, 0};   tbl[4].exp = 5'b00100;
        tbl[5].d = '{-1, 0, 0, 1};   tbl[5].exp = 5'b11001;
        for (int i = 0; i < 6; i++) begin
            run_a(tbl[i].d, 1'b0, 1'b0, bc);
            check("tbl_result", {27'd0, a_result}, {27'd0, tbl[i].exp});
            check("tbl_err", {31'd0, a_err}, 32'd0);
            check("tbl_busy_cycles", bc, 32'd6);
            accept_a();
        end
        bc_ref = 6;

        // Gapped digit_valid: same result, busy twice as long.
        dv4 = '{1, 0, -1, 1};
        run_a(dv4, 1'b1, 1'b0, bc);
        check("gap_result", {27'd0, a_result}, 32'd7);
        check("gap_busy_cycles", bc, 2 * bc_ref);
        accept_a();

        // Result held stable with ready low, then dropped by a new start.
        dv4 = '{1, 1, 0, 1};
        run_a(dv4, 1'b0, 1'b0, bc);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_result", {27'd0, a_result}, 32'd13);
            check("hold_rv", {31'd0, a_rv}, 32'd1);
        end
        dv4 = '{-1, 0, 1, 0};
        run_a(dv4, 1'b0, 1'b1, bc);
        check("overrun_new_result", {27'd0, a_result}, {27'd0, 5'b11010});
        accept_a();

        // Start in HOLD together with ready: handshake and restart, no overrun.
        dv4 = '{0, 0, 0, 1};
        run_a(dv4, 1'b0, 1'b0, bc);
        check("hs_first_result", {27'd0, a_result}, 32'd1);
        a_ready = 1'b1;
        dv4 = '{0, 1, 0, 0};
        run_a(dv4, 1'b0, 1'b0, bc);
        check("hs_second_result", {27'd0, a_result}, 32'd4);
        a_ready = 1'b0;
        accept_a();

        // Illegal code sets sticky digit_err; the next start clears it.
        dv4 = '{-2, 0, 0, 0};
        run_a(dv4, 1'b0, 1'b0, bc);
        check("illegal_result", {27'd0, a_result}, {27'd0, 5'b10000});
        check("illegal_err", {31'd0, a_err}, 32'd1);
        accept_a();
        check("illegal_err_sticky", {31'd0, a_err}, 32'd1);
        dv4 = '{1, 0, 0, 0};
        run_a(dv4, 1'b0, 1'b0, bc);
        check("err_cleared", {31'd0, a_err}, 32'd0);
        check("err_cleared_result", {27'd0, a_result}, 32'd8);
        accept_a();

        // Reset in the middle of COLLECT.
        apply_a(1'b1, 1'b1, 0);
        apply_a(1'b0, 1'b1, 1);
        apply_a(1'b0, 1'b1, -1);
        apply_a(1'b0, 1'b1, -2);
        apply_a(1'b0, 1'b1, 1);
        check("midcoll_err", {31'd0, a_err}, 32'd1);
        check("midcoll_busy", {31'd0, a_busy}, 32'd1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("midrst_rv", {31'd0, a_rv}, 32'd0);
        check("midrst_busy", {31'd0, a_busy}, 32'd0);
        check("midrst_err", {31'd0, a_err}, 32'd0);
        check("midrst_result", {27'd0, a_result}, 32'd0);
        dv4 = '{0, 1, 1, 0};
        run_a(dv4, 1'b0, 1'b0, bc);
        check("after_rst_result", {27'd0, a_result}, 32'd6);
        accept_a();

        // Start again in the middle of SKIP.
        apply_a(1'b1, 1'b1, 1);
        apply_a(1'b0, 1'b1, -1);
        dv4 = '{1, 1, 1, -1};
        run_a(dv4, 1'b0, 1'b0, bc);
        check("skip_restart_result", {27'd0, a_result}, 32'd13);
        accept_a();

        // Randomized operations against the positional-sum model.
        for (int it = 0; it < 30; it++) begin
            exp_err = 1'b0;
            for (int j = 0; j < 4; j++) begin
                dv4[j] = int'($urandom_range(0, 2)) - 1;
                if ($urandom_range(0, 7) == 0) dv4[j] = -2;
                if (dv4[j] == -2) exp_err = 1'b1;
            end
            exp5 = model_a(dv4);
            run_a(dv4, 1'($urandom_range(0, 1)), 1'b0, bc);
            check("rand_result", {27'd0, a_result}, {27'd0, exp5});
            check("rand_err", {31'd0, a_err}, {31'd0, exp_err});
            for (int w = 0; w < int'($urandom_range(0, 3)); w++) tick();
            check("rand_hold_result", {27'd0, a_result}, {27'd0, exp5});
            accept_a();
        end

        // Radix-4 instance.
        dv3 = '{3, -3, 2};
        run_b(dv3);
        check("b_result_38", {25'd0, b_result}, {25'd0, 7'b0100110});
        check("b_err_legal", {31'd0, b_err}, 32'd0);
        dv3 = '{-4, 0, 0};
        run_b(dv3);
        check("b_result_illegal", {25'd0, b_result}, {25'd0, 7'b1000000});
        check("b_err_illegal", {31'd0, b_err}, 32'd1);
        for (int it = 0; it < 10; it++) begin
            for (int j = 0; j < 3; j++) dv3[j] = int'($urandom_range(0, 6)) - 3;
            exp7 = model_b(dv3);
            run_b(dv3);
            check("b_rand_result", {25'd0, b_result}, {25'd0, exp7});
            check("b_rand_err", {31'd0, b_err}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
